// File: rtl/fp_mul_arb.sv
// ---------------------------------------------------------------------------
// fp_mul_arb
//
// A round-robin arbiter and two-stage sequencer that shares one external
// combinational IEEE-754 single-precision multiplier among NUM_REQ
// requesters. The winning operands are registered onto the multiplier
// inputs (stage 1). The product is registered back to the winner together
// with a one-hot valid (stage 2). The block accepts one multiply per cycle.
// Values are never inspected, so +/-0, INF and NaN pass through unchanged.
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous active-high reset
//   req       per-requester request; held with stable operands until granted
//   a_in      operand A per requester, requester i at [32i+31:32i]
//   b_in      operand B per requester, same packing as a_in
//   stall     freezes the whole block while high
//   gnt       one-hot combinational grant; accepted at the next rising edge
//   mul_a     registered operand A to the shared multiplier
//   mul_b     registered operand B to the shared multiplier
//   mul_out   product from the shared multiplier (combinational)
//   rsp_vld   one-hot registered response valid
//   rsp_data  registered product
//   busy      stage 1 or stage 2 holds a valid operation
// ---------------------------------------------------------------------------
module fp_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  a_in,
  input  logic [32*NUM_REQ-1:0]  b_in,
  input  logic                   stall,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_out,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic [31:0]            rsp_data,
  output logic                   busy
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Pointer and pipeline state
  logic [ID_W-1:0]    r_ptr;
  logic               r_s1_vld;
  logic [ID_W-1:0]    r_s1_id;
  logic [31:0]        r_mul_a;
  logic [31:0]        r_mul_b;
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [31:0]        r_rsp_data;

  // Arbitration results
  logic               w_found;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_take;
  logic [ID_W-1:0]    w_ptr_nxt;

  // Search the requests starting at r_ptr and wrapping modulo NUM_REQ.
  // The sum needs one extra bit, because ptr + k can reach 2*NUM_REQ-2
  // before it is folded back into range.
  always_comb begin
    logic [ID_W:0] v_sum;
    // NOTE: give every variable written here a default first. A path that
    // leaves one unassigned would infer a latch.
    w_found  = 1'b0;
    w_gnt_id = '0;
    v_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req[v_sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = v_sum[ID_W-1:0];
      end
    end
  end

  // A grant is only issued when the block can actually accept it.
  assign w_take    = w_found & ~stall & ~rst;
  assign gnt       = w_take ? (ONE << w_gnt_id) : '0;
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);

  // NOTE: every piece of state uses non-blocking assignments. As a result
  // each stage samples the previous stage's value from before the edge,
  // and this is what makes the two stages a true pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand and product registers are cleared as well as the
      // valids. Observers then see all-zero outputs after reset, and no
      // residue from a discarded operation remains.
      r_ptr      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_id    <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
    end else if (!stall) begin
      // Stage 1: capture the winner's operands for the shared multiplier.
      r_s1_vld <= w_take;
      if (w_take) begin
        r_ptr   <= w_ptr_nxt;
        r_s1_id <= w_gnt_id;
        r_mul_a <= a_in[{w_gnt_id, 5'b0} +: 32];
        r_mul_b <= b_in[{w_gnt_id, 5'b0} +: 32];
      end
      // Stage 2: return the settled product to the stage-1 owner.
      r_rsp_vld <= r_s1_vld ? (ONE << r_s1_id) : '0;
      if (r_s1_vld) begin
        r_rsp_data <= mul_out;
      end
    end
  end

  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;
  assign busy     = r_s1_vld | (|r_rsp_vld);

endmodule
